// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_if
// Description : Bundle between the serial pin side and the receiver.
//               master drives the line and consumes received words; slave is
//               the receiver.
//                 rx           - serial line, idle high, async to clk
//                 rx_data      - last received word, LSB = first data bit
//                 rx_valid     - one-cycle pulse, rx_data updated, frame good
//                 rx_frame_err - one-cycle pulse, a stop bit sampled low
//                 rx_busy      - high from start detection to last stop sample
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if #(
    parameter int PAYLOAD_WIDTH = 8
);
    logic                     rx;
    logic [PAYLOAD_WIDTH-1:0] rx_data;
    logic                     rx_valid;
    logic                     rx_frame_err;
    logic                     rx_busy;

    modport master (
        output rx,
        input  rx_data,
        input  rx_valid,
        input  rx_frame_err,
        input  rx_busy
    );

    modport slave (
        input  rx,
        output rx_data,
        output rx_valid,
        output rx_frame_err,
        output rx_busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : Asynchronous serial receiver, idle-high line, LSB first,
//               PAYLOAD_WIDTH data bits and STOP_BITS stop bits. The line is
//               resynchronised by two flops; every bit is sampled at its
//               centre, located by timing half a bit from the start edge.
// Ports       : clk   - system clock, rising edge
//               reset - asynchronous active-high reset
//               bus   - uart_rx_if slave: rx in; rx_data, rx_valid,
//                       rx_frame_err, rx_busy out
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int INPUT_CLK     = 100_000_000,
    parameter int BAUD_RATE     = 115200,
    parameter int PAYLOAD_WIDTH = 8,
    parameter int STOP_BITS     = 1
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);

    localparam int          c_CYCLES_PER_BIT = INPUT_CLK / BAUD_RATE;
    localparam logic [15:0] c_CPB_M1         = 16'(c_CYCLES_PER_BIT - 1);
    localparam logic [15:0] c_HALF_M1        = 16'(c_CYCLES_PER_BIT / 2 - 1);
    localparam logic [3:0]  c_LAST_DATA      = 4'(PAYLOAD_WIDTH - 1);
    localparam logic [3:0]  c_LAST_STOP      = 4'(STOP_BITS - 1);

    generate
        if (c_CYCLES_PER_BIT < 4 || c_CYCLES_PER_BIT > 65535) begin : g_bad_cpb
            $error("uart_rx: INPUT_CLK/BAUD_RATE must be within 4..65535");
        end
        if (PAYLOAD_WIDTH < 1 || PAYLOAD_WIDTH > 15) begin : g_bad_width
            $error("uart_rx: PAYLOAD_WIDTH must be within 1..15");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_rx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Synchronizer and edge detector reset high so a released reset on an
    // idle line never looks like a start edge.
    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= bus.rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    logic w_rx_s;
    logic w_fall;
    assign w_rx_s = r_sync2;
    assign w_fall = ~r_sync2 & r_prev;

    state_t                   r_state,  w_state_nxt;
    logic [15:0]              r_cnt,    w_cnt_nxt;
    logic [3:0]               r_idx,    w_idx_nxt;
    logic [PAYLOAD_WIDTH-1:0] r_shift,  w_shift_nxt;
    logic                     r_err,    w_err_nxt;
    logic [PAYLOAD_WIDTH-1:0] r_data,   w_data_nxt;
    logic                     r_valid,  w_valid_nxt;
    logic                     r_ferr,   w_ferr_nxt;
    logic                     r_busy,   w_busy_nxt;

    logic [15:0]              w_cnt_inc;
    logic [PAYLOAD_WIDTH-1:0] w_shifted;
    logic                     w_stop_err;

    assign w_cnt_inc  = r_cnt + 16'd1;
    // New sample enters at the MSB; after PAYLOAD_WIDTH shifts the first
    // received bit has reached the LSB.
    assign w_shifted  = (r_shift >> 1) |
                        (PAYLOAD_WIDTH'(w_rx_s) << (PAYLOAD_WIDTH - 1));
    // Error flag including the stop sample being taken this cycle.
    assign w_stop_err = r_err | ~w_rx_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_err   <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_err   <= w_err_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_err_nxt   = r_err;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                // Only a high-to-low transition arms the receiver, so a line
                // stuck low yields a single framing error and then stays quiet.
                if (w_fall) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_cnt_nxt = w_cnt_inc;
                if (r_cnt == c_HALF_M1) begin
                    w_cnt_nxt   = '0;
                    // Line back high at mid start bit: treat as a glitch.
                    w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                w_cnt_nxt = w_cnt_inc;
                if (r_cnt == c_CPB_M1) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = w_shifted;
                    if (r_idx == c_LAST_DATA) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end
            end
            S_STOP: begin
                w_cnt_nxt = w_cnt_inc;
                if (r_cnt == c_CPB_M1) begin
                    w_cnt_nxt = '0;
                    if (r_idx == c_LAST_STOP) begin
                        // Finish at the centre of the last stop bit so a start
                        // edge arriving early in the next frame is not missed.
                        w_data_nxt  = r_shift;
                        w_valid_nxt = ~w_stop_err;
                        w_ferr_nxt  = w_stop_err;
                        w_err_nxt   = 1'b0;
                        w_idx_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_err_nxt = w_stop_err;
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign bus.rx_data      = r_data;
    assign bus.rx_valid     = r_valid;
    assign bus.rx_frame_err = r_ferr;
    assign bus.rx_busy      = r_busy;

endmodule
`default_nettype wire
